// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit x74283 slice, stepped one nibble per clock, LSB first.
// Define NIBBLE_SUB_EN to add the `sub` port, which selects A-B instead of A+B+cin.

module x74283 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_1,
    output logic [3:0] S,
    output logic       C4
);
    assign {C4, S} = {1'b0, A} + {1'b0, B} + {4'b0000, C_1};
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         CP,
    input  logic         CR,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cin,
`ifdef NIBBLE_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         CO,
    output logic         OVF
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   s_q, s_d;
    logic           co_q, co_d;
    logic           ovf_q, ovf_d;

    logic [3:0]     slice_a, slice_b, slice_s;
    logic           slice_co;

    assign slice_a = opa_q[4*idx_q +: 4];
    assign slice_b = opb_q[4*idx_q +: 4];

    x74283 u_slice (
        .A   (slice_a),
        .B   (slice_b),
        .C_1 (carry_q),
        .S   (slice_s),
        .C4  (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = A;
                    // opB holds the effective addend, so OVF can use it directly
`ifdef NIBBLE_SUB_EN
                    if (sub) begin
                        opb_d   = ~B;
                        carry_d = 1'b1;
                    end else begin
                        opb_d   = B;
                        carry_d = cin;
                    end
`else
                    opb_d   = B;
                    carry_d = cin;
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[4*idx_q +: 4] = slice_s;
                carry_d = slice_co;
                if (idx_q == LAST) begin
                    co_d    = slice_co;
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (slice_s[3] != opa_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign CO        = co_q;
    assign OVF       = ovf_q;

endmodule
